// File: rtl/and_gate.sv
// and_gate: combinational a&b plus one registered result stage with zero/ones/popcount flags (AND_GATE_FLAGS_EN).
// Latency: out 0 cycles, out_q 1 cycle after accept. Backpressure: in_ready = !out_valid || out_ready.
module and_gate #(
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(WIDTH + 1)
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             res_zero,
  output logic             res_ones,
  output logic [PW-1:0]    res_pop
);

  logic [WIDTH-1:0] and_ab;
  logic             capture;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign and_ab   = a & b;
  assign out      = and_ab;
  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // A capture wins over a drain on the same edge, keeping 1 result per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = and_ab;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_q     = data_q;

`ifdef AND_GATE_FLAGS_EN
  function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + PW'(v[i]);
    end
    return s;
  endfunction

  logic          zero_q, zero_d;
  logic          ones_q, ones_d;
  logic [PW-1:0] pop_q, pop_d;

  // Flags are derived from the value being registered so they track out_q exactly.
  always_comb begin
    zero_d = zero_q;
    ones_d = ones_q;
    pop_d  = pop_q;
    if (capture) begin
      zero_d = ~|and_ab;
      ones_d = &and_ab;
      pop_d  = popcnt(and_ab);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
      ones_q <= 1'b0;
      pop_q  <= '0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
      pop_q  <= pop_d;
    end
  end

  assign res_zero = zero_q;
  assign res_ones = ones_q;
  assign res_pop  = pop_q;
`else
  assign res_zero = 1'b0;
  assign res_ones = 1'b0;
  assign res_pop  = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: transaction-level model of the result register plus directed vectors.
module tb_and_gate;
  localparam int WIDTH = 32;
  localparam int PW    = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] out, a, b, out_q;
  logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic             res_zero, res_ones;
  logic [PW-1:0]    res_pop;

  int checks = 0;
  int errors = 0;

  and_gate #(.WIDTH(WIDTH)) dut (
    .out(out), .a(a), .b(b), .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .res_zero(res_zero),
    .res_ones(res_ones), .res_pop(res_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flag expectations, zero when the flag feature is compiled out.
  function automatic logic [63:0] f_zero(input logic [WIDTH-1:0] v);
`ifdef AND_GATE_FLAGS_EN
    return {63'd0, v == '0};
`else
    return 64'd0;
`endif
  endfunction
  function automatic logic [63:0] f_ones(input logic [WIDTH-1:0] v);
`ifdef AND_GATE_FLAGS_EN
    return {63'd0, v == {WIDTH{1'b1}}};
`else
    return 64'd0;
`endif
  endfunction
  function automatic logic [63:0] f_pop(input logic [WIDTH-1:0] v);
`ifdef AND_GATE_FLAGS_EN
    return 64'($countones(v));
`else
    return 64'd0;
`endif
  endfunction
  function automatic logic [63:0] lit_flag(input logic [63:0] v);
`ifdef AND_GATE_FLAGS_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  // Model: one result slot; a slot that is empty or being taken accepts new operands.
  logic             m_vld;
  logic [WIDTH-1:0] m_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 1'b0;
      m_q   = '0;
    end else if (in_valid && (!m_vld || out_ready)) begin
      m_vld = 1'b1;
      m_q   = a & b;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_out", 64'(out), 64'(a & b));
    chk("cmp_in_ready", 64'(in_ready), 64'(!m_vld || out_ready));
    chk("cmp_out_valid", 64'(out_valid), 64'(m_vld));
    chk("cmp_out_q", 64'(out_q), 64'(m_q));
    chk("cmp_res_zero", 64'(res_zero), f_zero(m_q));
    chk("cmp_res_ones", 64'(res_ones), f_ones(m_q));
    chk("cmp_res_pop", 64'(res_pop), f_pop(m_q));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] b2b_a [4] = '{32'd1, 32'd2, 32'd4, 32'd8};
  logic [WIDTH-1:0] b2b_b [4] = '{32'd1, 32'd3, 32'd4, 32'd7};
  logic [WIDTH-1:0] b2b_q [4] = '{32'd1, 32'd2, 32'd4, 32'd0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_q", 64'(out_q), 64'd0);
    chk("rst_res_zero", 64'(res_zero), lit_flag(64'd1));
    chk("rst_res_ones", 64'(res_ones), 64'd0);
    chk("rst_res_pop", 64'(res_pop), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Combinational sweep, operands changing every 50 time units.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        a = WIDTH'(i); b = WIDTH'(j);
        #1;
        chk("sweep_out", 64'(out), 64'(i & j));
        if (i == 45 && j == 27) chk("sweep_45_27", 64'(out), 64'd9);
        #49;
      end
    end

    // Registered path.
    step();
    in_valid = 1'b1; a = 32'h3C; b = 32'h0F; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("reg_out_valid", 64'(out_valid), 64'd1);
    chk("reg_out_q", 64'(out_q), 64'h0C);
    chk("reg_res_pop", 64'(res_pop), lit_flag(64'd2));
    chk("reg_res_zero", 64'(res_zero), 64'd0);
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure.
    in_valid = 1'b1; a = 32'h30; b = 32'h21; out_ready = 1'b0;
    step();
    a = 32'h3F; b = 32'h3F;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_q", 64'(out_q), 64'h20);
    step();
    step();
    chk("bp_hold_out_q", 64'(out_q), 64'h20);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_capture_out_q", 64'(out_q), 64'h3F);

    // Asynchronous reset between edges.
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_q", 64'(out_q), 64'd0);
    chk("arst_out_comb", 64'(out), 64'h3F);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Flag extremes.
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    step();
    chk("ones_out_q", 64'(out_q), 64'hFFFFFFFF);
    chk("ones_res_ones", 64'(res_ones), lit_flag(64'd1));
    chk("ones_res_pop", 64'(res_pop), lit_flag(64'd32));
    a = 32'hAAAAAAAA; b = 32'h55555555;
    step();
    chk("zero_out_q", 64'(out_q), 64'd0);
    chk("zero_res_zero", 64'(res_zero), lit_flag(64'd1));
    chk("zero_res_pop", 64'(res_pop), 64'd0);

    // Back-to-back at one result per cycle.
    for (int k = 0; k < 4; k++) begin
      a = b2b_a[k]; b = b2b_b[k];
      step();
      chk("b2b_out_q", 64'(out_q), 64'(b2b_q[k]));
      chk("b2b_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/and_gate.md
# and_gate

32-bit bitwise AND unit for the ALU boolean group. A purely combinational result `out = a & b` is always available. A single registered result stage with valid/ready handshake carries the result plus status flags, so the boolean group can feed the ALU's clocked result path.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; legal range 1..64.
- `PW`, default `$clog2(WIDTH+1)` (6 at WIDTH=32): popcount width; derived, not overridden.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `out`  out  WIDTH: combinational `a & b`.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `in_valid`  in  1: `a`/`b` presented for capture.
- `in_ready`  out  1: stage can accept this cycle.
- `out_valid`  out  1: registered result valid.
- `out_ready`  in  1: consumer takes the registered result.
- `out_q`  out  WIDTH: registered `a & b`.
- `res_zero`  out  1: registered, `out_q == 0`.
- `res_ones`  out  1: registered, `out_q` all ones.
- `res_pop`  out  PW: registered count of 1-bits in `out_q`.

Port declaration order: `out, a, b` first, then `clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_q, res_zero, res_ones, res_pop`. This keeps positional 3-port instantiation `(out, a, b)` valid.

## Operation
- `out` is the bit-for-bit AND of `a` and `b`, with no clock dependency.
- `in_ready = !out_valid || out_ready`, combinational.
- Capture on rising `clk` when `in_valid && in_ready`:
  - `out_q <= a & b`.
  - Flags are computed from the captured value.
  - `out_valid <= 1`.
- If `out_valid && out_ready` and there is no new capture in the same edge, `out_valid <= 0`.
- Simultaneous drain and capture: the new result replaces the old one and `out_valid` stays 1, so throughput is 1 per cycle.
- While `out_valid && !out_ready`:
  - `out_q` and all flags hold stable.
  - `in_ready = 0`, and input is ignored.
- Full-width operands are legal with no masking. For example, at WIDTH=32, `0xFFFFFFFF & 0xFFFFFFFF` gives `res_ones=1` and `res_pop=32`.
- `res_pop` is a sum tree over `out_q` bits. Its range is 0..WIDTH, and it never wraps.

## Timing
- `out`: zero-cycle latency. It follows `a`/`b` within the same delta/combinational settle.
- Registered result: latency 1 cycle from the accepted `in_valid` edge to `out_valid=1`.
- Reset (`rst_n=0`, asynchronous):
  - `out_valid=0`, `out_q=0`, `res_zero=1`, `res_ones=0`, `res_pop=0`.
  - `out` remains combinational and is unaffected by reset.
- Reset asserted mid-transfer discards the held result immediately. After reset deasserts, the first capture is on the next edge with `in_valid=1`.
- Reset deassertion is taken synchronously by the next rising edge. There is no capture on the deassertion edge's cycle if `rst_n` was low at that edge.

## Configuration
- `AND_GATE_FLAGS_EN`:
  - Defined: `res_zero`, `res_ones` and `res_pop` are computed and registered as above.
  - Undefined: all three ports exist but are driven constant 0, including during reset, and their logic is removed. `out`, `out_q` and the handshake behave identically.

## Test plan
- Exhaustive low-range sweep: `a`,`b` each 0..63, changing every 50 time units -> `out == a & b` at every step. For example, `a=45`, `b=27` gives `out=9`.
- Registered path: `in_valid=1`, `a=0x3C`, `b=0x0F`, `out_ready=1` -> next edge `out_valid=1`, `out_q=0x0C`, `res_pop=2`, `res_zero=0` (flags with `AND_GATE_FLAGS_EN`).
- Backpressure: hold `out_ready=0` after the capture of `0x30&0x21` -> `in_ready=0`. A new `in_valid` with `a=b=0x3F` is ignored and `out_q` holds `0x20`. Release `out_ready` -> capture proceeds.
- Flag extremes with `AND_GATE_FLAGS_EN`:
  - `a=b=0xFFFFFFFF` -> `res_ones=1`, `res_pop=32`.
  - `a=0xAAAAAAAA`, `b=0x55555555` -> `res_zero=1`, `res_pop=0`.
- Asynchronous reset mid-operation: with `out_valid=1` and `out_q=0x3F`, drop `rst_n` between edges -> `out_valid=0` and `out_q=0` immediately, while `out` still equals the current `a&b`.
- Back-to-back: `in_valid` and `out_ready` held 1 for 4 cycles with operands 1/1, 2/3, 4/4, 8/7 -> successive `out_q` values 1, 2, 4, 0 and `out_valid` constantly 1.
